// File: rtl/dmem_responder.sv
// ============================================================================
// dmem_responder
// ----------------------------------------------------------------------------
// Data-memory responder for the RISC-V core's load/store port. It is the
// target end of the core's data request/response handshake: it accepts one
// request at a time and waits out a configurable number of wait states. It
// then performs a byte/half/word access on an internal word RAM and presents
// a response that is held until the core consumes it.
//
// Parameters
//   DEPTH_WORDS  number of 32-bit words of storage (power of 2, >= 2)
//   WAIT_CYCLES  wait states between accept and response (0..15)
//   ADDR_BASE    byte address of word 0 (word aligned)
//
// Ports
//   i_clk           rising-edge clock
//   i_rst           synchronous reset, active-high
//   i_req_valid     request present
//   o_req_ready     responder can accept a request (only while idle)
//   i_req_we        1 = store, 0 = load
//   i_req_addr      byte address
//   i_req_wdata     store data, right-aligned (byte in [7:0], half in [15:0])
//   i_req_size      00 = byte, 01 = half, 10 = word, 11 = reserved
//   i_req_unsigned  loads zero-extend when 1, sign-extend when 0
//   o_rsp_valid     response present
//   i_rsp_ready     core accepts the response
//   o_rsp_rdata     extended load result; 0 for stores and errors
//   o_rsp_err       access error (out of range / reserved size / misaligned)
//
// Configuration macro
//   MISALIGN_CHECK_EN  when defined, a half access with addr[0]=1 or a word
//                      access with addr[1:0]!=0 is rejected with an error.
//                      When undefined, such addresses are aligned down and
//                      only range and reserved-size errors are reported.
// ============================================================================
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    input  logic [1:0]  i_req_size,
    input  logic        i_req_unsigned,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH_WORDS) << 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      r_state;
    state_t      w_next_state;

    // Captured request
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;

    // Wait-state counter and held response
    logic [3:0]  r_cnt;
    logic [31:0] r_rdata;
    logic        r_err;

    // Storage
    logic [31:0] r_mem [DEPTH_WORDS];

    // Decoded access
    logic             w_accept;
    logic             w_enter_resp;
    logic [31:0]      w_offset;
    logic [1:0]       w_lane;
    logic [IDX_W-1:0] w_idx;
    logic             w_out_of_range;
    logic             w_misalign;
    logic             w_err;
    logic [3:0]       w_be;
    logic [31:0]      w_wlanes;
    logic [31:0]      w_rword;
    logic [7:0]       w_byte;
    logic [15:0]      w_half;
    logic [31:0]      w_load;
    logic [31:0]      w_rsp_data;
    logic             w_mem_we;

    assign w_accept     = (r_state == ST_IDLE) && i_req_valid;
    assign w_enter_resp = (r_state == ST_WAIT) && (r_cnt == 4'd0);

    assign o_req_ready  = (r_state == ST_IDLE);
    assign o_rsp_valid  = (r_state == ST_RESP);
    assign o_rsp_rdata  = r_rdata;
    assign o_rsp_err    = r_err;

    // Every accepted request passes through WAIT, even with zero wait states:
    // the cycle after the accept edge is the one in which the captured request
    // is decoded, so the counter is loaded with the full WAIT_CYCLES and RESP
    // is entered WAIT_CYCLES+1 edges after the accept edge.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (i_req_valid)    w_next_state = ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd0)  w_next_state = ST_RESP;
            ST_RESP: if (i_rsp_ready)    w_next_state = ST_IDLE;
            default:                     w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Address decode of the captured request. ADDR_BASE is word aligned, so
    // the low bits of the offset are the same as the low address bits.
    always_comb begin
        w_offset       = r_addr - ADDR_BASE;
        w_lane         = w_offset[1:0];
        w_idx          = w_offset[IDX_W+1:2];
        w_out_of_range = (r_addr < ADDR_BASE) || ({1'b0, w_offset} >= BYTE_LIMIT);
    end

`ifdef MISALIGN_CHECK_EN
    // Halves must sit on even addresses and words on multiples of four.
    always_comb begin
        w_misalign = 1'b0;
        case (r_size)
            2'b01:   w_misalign = w_lane[0];
            2'b10:   w_misalign = (w_lane != 2'b00);
            default: w_misalign = 1'b0;
        endcase
    end
`else
    // Misaligned halves/words are aligned down by the lane decode below.
    always_comb begin
        w_misalign = 1'b0;
    end
`endif

    // Lane selection for both directions. Stores replicate the right-aligned
    // data across all lanes and rely on byte enables to pick the target bytes.
    // Any error clears the enables so nothing is written.
    always_comb begin
        w_rword  = r_mem[w_idx];
        w_byte   = w_rword[{w_lane, 3'b000} +: 8];
        w_half   = w_lane[1] ? w_rword[31:16] : w_rword[15:0];
        w_err    = w_out_of_range || w_misalign;
        w_be     = 4'b0000;
        w_wlanes = 32'h0000_0000;
        w_load   = 32'h0000_0000;
        case (r_size)
            2'b00: begin
                w_be     = 4'b0001 << w_lane;
                w_wlanes = {4{r_wdata[7:0]}};
                w_load   = r_unsigned ? {24'h000000, w_byte}
                                      : {{24{w_byte[7]}}, w_byte};
            end
            2'b01: begin
                w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{r_wdata[15:0]}};
                w_load   = r_unsigned ? {16'h0000, w_half}
                                      : {{16{w_half[15]}}, w_half};
            end
            2'b10: begin
                w_be     = 4'b1111;
                w_wlanes = r_wdata;
                w_load   = w_rword;
            end
            default: begin
                w_err    = 1'b1;
            end
        endcase
        if (w_err) begin
            w_be   = 4'b0000;
            w_load = 32'h0000_0000;
        end
        w_rsp_data = r_we ? 32'h0000_0000 : w_load;
    end

    // The single RAM access happens on the edge that enters RESP. Reset wins
    // over that edge, so a store caught by reset while waiting is dropped.
    assign w_mem_we = w_enter_resp && r_we && !i_rst;

    // Storage is deliberately not reset.
    always_ff @(posedge i_clk) begin
        if (w_mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= w_wlanes[b*8 +: 8];
                end
            end
        end
    end

    // Request capture, wait-state counting and the held response. Inputs are
    // only captured on acceptance, so they are ignored in WAIT and RESP, and
    // the response registers stay stable until the next access completes.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_we       <= 1'b0;
            r_addr     <= 32'h0000_0000;
            r_wdata    <= 32'h0000_0000;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
            r_cnt      <= 4'd0;
            r_rdata    <= 32'h0000_0000;
            r_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we       <= i_req_we;
                r_addr     <= i_req_addr;
                r_wdata    <= i_req_wdata;
                r_size     <= i_req_size;
                r_unsigned <= i_req_unsigned;
                r_cnt      <= 4'(WAIT_CYCLES);
            end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_enter_resp) begin
                r_rdata <= w_rsp_data;
                r_err   <= w_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// ============================================================================
// tb_dmem_responder
// ----------------------------------------------------------------------------
// Self-checking bench for dmem_responder with WAIT_CYCLES=1, ADDR_BASE=0 and
// DEPTH_WORDS=256. Directed requests push their hand-computed response into a
// scoreboard queue; an independent monitor pops and compares on every
// response handshake. Handshake timing is checked inline by the stimulus.
// Honours MISALIGN_CHECK_EN to pick the expected misaligned-access results.
// ============================================================================
module tb_dmem_responder;

    logic        clk;
    logic        rst;
    logic        reqValid;
    logic        reqReady;
    logic        reqWe;
    logic [31:0] reqAddr;
    logic [31:0] reqWdata;
    logic [1:0]  reqSize;
    logic        reqUnsigned;
    logic        rspValid;
    logic        rspReady;
    logic [31:0] rspRdata;
    logic        rspErr;

    int passCount;
    int checkCount;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    rsp_t expQueue[$];

    dmem_responder #(
        .DEPTH_WORDS(256),
        .WAIT_CYCLES(1),
        .ADDR_BASE  (32'h0000_0000)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req_valid   (reqValid),
        .o_req_ready   (reqReady),
        .i_req_we      (reqWe),
        .i_req_addr    (reqAddr),
        .i_req_wdata   (reqWdata),
        .i_req_size    (reqSize),
        .i_req_unsigned(reqUnsigned),
        .o_rsp_valid   (rspValid),
        .i_rsp_ready   (rspReady),
        .o_rsp_rdata   (rspRdata),
        .o_rsp_err     (rspErr)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: counts it and reports a FAIL line when it misses.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", name, actual, expected);
        end
    endtask

    // Scoreboard monitor: responses are consumed on the next rising edge when
    // valid and ready are both high, so sample them on the falling edge.
    always @(negedge clk) begin
        if (!rst && rspValid && rspReady) begin
            if (expQueue.size() == 0) begin
                checkOutput("sb_unexpected_rsp", 32'd1, 32'd0);
            end else begin
                rsp_t exp;
                exp = expQueue.pop_front();
                checkOutput("rsp_rdata", rspRdata, exp.rdata);
                checkOutput("rsp_err", {31'd0, rspErr}, {31'd0, exp.err});
            end
        end
    end

    // Drives one request and waits (bounded) for acceptance. Returns at the
    // accept edge + 1 time unit with reqValid dropped. The expected response
    // is queued when expectRsp is set.
    task automatic applyStimulus(input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [1:0] size,
                                 input logic uns, input logic [31:0] expRdata,
                                 input logic expErr, input logic expectRsp,
                                 output logic accepted);
        rsp_t exp;
        accepted    = 1'b0;
        reqValid    = 1'b1;
        reqWe       = we;
        reqAddr     = addr;
        reqWdata    = wdata;
        reqSize     = size;
        reqUnsigned = uns;
        for (int k = 0; k < 20; k++) begin
            if (reqReady) begin
                accepted = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!accepted) begin
            checkOutput("accept_timeout", 32'd1, 32'd0);
            reqValid = 1'b0;
        end else begin
            if (expectRsp) begin
                exp.rdata = expRdata;
                exp.err   = expErr;
                expQueue.push_back(exp);
            end
            @(posedge clk);
            #1;
            reqValid = 1'b0;
        end
    endtask

    // Full transaction with the core always ready, checking that the response
    // appears exactly two edges after the accept edge and lasts one cycle.
    task automatic runTxn(input string name, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size,
                          input logic uns, input logic [31:0] expRdata,
                          input logic expErr);
        logic ok;
        rspReady = 1'b1;
        applyStimulus(we, addr, wdata, size, uns, expRdata, expErr, 1'b1, ok);
        if (ok) begin
            checkOutput({name, "_busy_ready"}, {31'd0, reqReady}, 32'd0);
            @(posedge clk);
            #1;
            checkOutput({name, "_lat1_valid"}, {31'd0, rspValid}, 32'd0);
            @(posedge clk);
            #1;
            checkOutput({name, "_lat2_valid"}, {31'd0, rspValid}, 32'd1);
            @(posedge clk);
            #1;
            checkOutput({name, "_done_valid"}, {31'd0, rspValid}, 32'd0);
        end
    endtask

    // Watchdog so a stuck design can never hang the run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic ok;
        logic [31:0] misWordData;
        logic        misWordErr;
        logic [31:0] misHalfData;
        logic        misHalfErr;

        passCount   = 0;
        checkCount  = 0;
        rst         = 1'b1;
        reqValid    = 1'b0;
        reqWe       = 1'b0;
        reqAddr     = 32'h0;
        reqWdata    = 32'h0;
        reqSize     = 2'b00;
        reqUnsigned = 1'b0;
        rspReady    = 1'b1;

`ifdef MISALIGN_CHECK_EN
        misWordData = 32'h0000_0000;
        misWordErr  = 1'b1;
        misHalfData = 32'h0000_0000;
        misHalfErr  = 1'b1;
`else
        misWordData = 32'hBEEF_3344;
        misWordErr  = 1'b0;
        misHalfData = 32'h0000_3344;
        misHalfErr  = 1'b0;
`endif

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("reset_req_ready", {31'd0, reqReady}, 32'd1);
        checkOutput("reset_rsp_valid", {31'd0, rspValid}, 32'd0);
        checkOutput("reset_rsp_rdata", rspRdata, 32'd0);
        checkOutput("reset_rsp_err", {31'd0, rspErr}, 32'd0);

        // Word store and load-back.
        runTxn("sw10", 1'b1, 32'h10, 32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0, 1'b0);
        runTxn("lw10", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0);

        // Byte store into a known word, then sign/zero-extended loads.
        runTxn("sw10b", 1'b1, 32'h10, 32'h1122_3344, 2'b10, 1'b0, 32'h0, 1'b0);
        runTxn("sb13", 1'b1, 32'h13, 32'hFFFF_FF80, 2'b00, 1'b0, 32'h0, 1'b0);
        runTxn("lb13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0);
        runTxn("lbu13", 1'b0, 32'h13, 32'h0, 2'b00, 1'b1, 32'h0000_0080, 1'b0);
        runTxn("lw10c", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'h8022_3344, 1'b0);

        // Half and byte lanes.
        runTxn("lh12", 1'b0, 32'h12, 32'h0, 2'b01, 1'b0, 32'hFFFF_8022, 1'b0);
        runTxn("lhu10", 1'b0, 32'h10, 32'h0, 2'b01, 1'b1, 32'h0000_3344, 1'b0);
        runTxn("lb11", 1'b0, 32'h11, 32'h0, 2'b00, 1'b0, 32'h0000_0033, 1'b0);
        runTxn("sh12", 1'b1, 32'h12, 32'hFFFF_BEEF, 2'b01, 1'b0, 32'h0, 1'b0);
        runTxn("lw10d", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hBEEF_3344, 1'b0);

        // Back-pressure: response held for 5 cycles while a new request waits.
        rspReady = 1'b0;
        applyStimulus(1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hBEEF_3344, 1'b0, 1'b1, ok);
        if (ok) begin
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            reqValid    = 1'b1;
            reqWe       = 1'b0;
            reqAddr     = 32'h13;
            reqSize     = 2'b00;
            reqUnsigned = 1'b1;
            for (int c = 0; c < 5; c++) begin
                checkOutput("stall_valid", {31'd0, rspValid}, 32'd1);
                checkOutput("stall_rdata", rspRdata, 32'hBEEF_3344);
                checkOutput("stall_req_ready", {31'd0, reqReady}, 32'd0);
                @(posedge clk);
                #1;
            end
            rspReady = 1'b1;
            @(posedge clk);
            #1;
            checkOutput("bubble_req_ready", {31'd0, reqReady}, 32'd1);
            checkOutput("bubble_rsp_valid", {31'd0, rspValid}, 32'd0);
            begin
                rsp_t exp;
                exp.rdata = 32'h0000_00BE;
                exp.err   = 1'b0;
                expQueue.push_back(exp);
            end
            @(posedge clk);
            #1;
            reqValid = 1'b0;
            checkOutput("after_accept_ready", {31'd0, reqReady}, 32'd0);
            @(posedge clk);
            #1;
            @(posedge clk);
            #1;
            checkOutput("queued_rsp_valid", {31'd0, rspValid}, 32'd1);
            @(posedge clk);
            #1;
        end

        // Range boundary: last word works, first word past the end errors
        // and must not alias onto word 0.
        runTxn("sw0", 1'b1, 32'h0, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0, 1'b0);
        runTxn("sw3fc", 1'b1, 32'h3FC, 32'h0102_0304, 2'b10, 1'b0, 32'h0, 1'b0);
        runTxn("lw3fc", 1'b0, 32'h3FC, 32'h0, 2'b10, 1'b0, 32'h0102_0304, 1'b0);
        runTxn("sw400", 1'b1, 32'h400, 32'h5555_5555, 2'b10, 1'b0, 32'h0, 1'b1);
        runTxn("lw400", 1'b0, 32'h400, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1);
        runTxn("lw0", 1'b0, 32'h0, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0);

        // Reserved size: error, no write.
        runTxn("lres", 1'b0, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
        runTxn("sres", 1'b1, 32'h10, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1);
        runTxn("lw10e", 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hBEEF_3344, 1'b0);

        // Misaligned accesses.
        runTxn("lw12", 1'b0, 32'h12, 32'h0, 2'b10, 1'b0, misWordData, misWordErr);
        runTxn("lh11", 1'b0, 32'h11, 32'h0, 2'b01, 1'b0, misHalfData, misHalfErr);

        // Reset during WAIT discards the captured store.
        runTxn("sw20", 1'b1, 32'h20, 32'h1234_5678, 2'b10, 1'b0, 32'h0, 1'b0);
        rspReady = 1'b1;
        applyStimulus(1'b1, 32'h20, 32'hA5A5_A5A5, 2'b10, 1'b0, 32'h0, 1'b0, 1'b0, ok);
        if (ok) begin
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            checkOutput("rstwait_rsp_valid", {31'd0, rspValid}, 32'd0);
            checkOutput("rstwait_req_ready", {31'd0, reqReady}, 32'd1);
            @(posedge clk);
            #1;
            checkOutput("rstwait_still_idle", {31'd0, rspValid}, 32'd0);
        end
        runTxn("lw20", 1'b0, 32'h20, 32'h0, 2'b10, 1'b0, 32'h1234_5678, 1'b0);

        // Every queued response must have been seen.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("sb_drained", expQueue.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
